hilo_muldiv_unit: RTL and testbench

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

---
 rtl/hilo_muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply-divide unit: radix-2 shift-add multiply,
// restoring divide, MADD accumulate and MTHI/MTLO moves.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t           state_q;
  logic             div_q;
  logic             madd_q;
  logic             neg_q;
  logic             negr_q;
  logic             zero_q;
  logic [CW-1:0]    cnt_q;
  logic [W-1:0]     opd_q;
  logic [2*W-1:0]   p_q;
  logic [W-1:0]     hi_q;
  logic [W-1:0]     lo_q;
  logic             dz_q;

  logic             sa;
  logic             sb;
  logic [W-1:0]     mag_a;
  logic [W-1:0]     mag_b;
  logic [W:0]       wide;
  logic [W-1:0]     sub;
  logic [W:0]       sum;
  logic [2*W-1:0]   p_d;
  logic [2*W-1:0]   prod;
  logic [2*W-1:0]   acc;
  logic [W-1:0]     hi_d;
  logic [W-1:0]     lo_d;

  // Operand magnitudes for signed ops (even ops are signed)
  always_comb begin
    sa    = ~op[0] & a[W-1];
    sb    = ~op[0] & b[W-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
  end

  // One radix-2 step: shift-add or restoring shift-subtract
  always_comb begin
    wide = {p_q[2*W-1:W], p_q[W-1]};
    sub  = wide[W-1:0] - opd_q;
    sum  = {1'b0, p_q[2*W-1:W]}
         + (p_q[0] ? {1'b0, opd_q} : '0);
    p_d  = p_q;
    if (div_q) begin
      if (wide >= {1'b0, opd_q})
        p_d = {sub, p_q[W-2:0], 1'b1};
      else
        p_d = {wide[W-1:0], p_q[W-2:0], 1'b0};
    end else begin
      p_d = {sum, p_q[W-1:1]};
    end
  end

  // Sign correction and accumulation for the FIX cycle
  always_comb begin
    prod = neg_q ? -p_q : p_q;
    acc  = {hi_q, lo_q} + prod;
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_q) begin
      if (!zero_q) begin
        lo_d = neg_q  ? -p_q[W-1:0]   : p_q[W-1:0];
        hi_d = negr_q ? -p_q[2*W-1:W] : p_q[2*W-1:W];
      end
    end else if (madd_q) begin
      {hi_d, lo_d} = acc;
    end else begin
      {hi_d, lo_d} = prod;
    end
  end

  // Control FSM, operand latches and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= 1'b0;
      madd_q  <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      opd_q   <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          dz_q <= 1'b0;
          if (start) begin
            if (op[2:1] == 2'b11) begin
              if (op[0]) lo_q <= a;
              else       hi_q <= a;
            end else begin
              div_q   <= op[2];
              madd_q  <= op[1] & ~op[2];
              neg_q   <= sa ^ sb;
              negr_q  <= sa;
              zero_q  <= (b == '0);
              opd_q   <= op[2] ? mag_b : mag_a;
              p_q     <= {{W{1'b0}},
                          op[2] ? mag_a : mag_b};
              cnt_q   <= CW'(W - 1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          p_q <= p_d;
          if (cnt_q == '0) state_q <= FIX;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          dz_q    <= div_q & zero_q;
          state_q <= DONE;
        end
        DONE: begin
          dz_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: vector table, random
// model-checked ops, abort/ignore sequences, WIDTH=8 case.
module tb_hilo_muldiv_unit;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int nerr = 0;
  int nchk = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(dz)
  );

  hilo_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .hi(hi8), .lo(lo8), .div_by_zero(dz8)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Wait for done from cycle 1; returns cycle count.
  task automatic wait_done(input string nm,
                           output int cyc);
    bit dz_early;
    cyc = 1;
    dz_early = 0;
    chk({nm, " busy"}, busy, 1);
    while (!done && cyc < 60) begin
      if (dz) dz_early = 1;
      @(negedge clk);
      cyc++;
    end
    chk({nm, " done"}, done, 1);
    chk({nm, " latency"}, cyc, 34);
    chk({nm, " dz early"}, dz_early, 0);
  endtask

  task automatic pop_cmp(input string nm);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({nm, " queue"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk({nm, " hi"}, hi, e.hi);
      chk({nm, " lo"}, lo, e.lo);
      chk({nm, " dz"}, dz, e.dz);
    end
  endtask

  // Called at a negedge with the DUT idle.
  task automatic run_op(input logic [2:0] o,
                        input logic [31:0] av,
                        input logic [31:0] bv,
                        input exp_t e,
                        input string nm);
    int cyc;
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (o[2:1] == 2'b11) begin
      chk({nm, " mt busy"}, busy, 0);
      chk({nm, " mt done"}, done, 0);
      chk({nm, " mt hi"}, hi, e.hi);
      chk({nm, " mt lo"}, lo, e.lo);
    end else begin
      sb_q.push_back(e);
      wait_done(nm, cyc);
      pop_cmp(nm);
      @(negedge clk);
      chk({nm, " idle busy"}, busy, 0);
      chk({nm, " idle dz"}, dz, 0);
    end
  endtask

  initial begin
    vec_t tv[16];
    exp_t e;
    logic [31:0] mhi, mlo;
    logic [63:0] pr;
    int cyc;

    tv[0]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1'b0};
    tv[1]  = '{3'b000, 32'hFFFFFFFD, 32'h00000007,
               32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tv[2]  = '{3'b110, 32'h00000000, 32'h0,
               32'h00000000, 32'hFFFFFFEB, 1'b0};
    tv[3]  = '{3'b111, 32'hFFFFFFFF, 32'h0,
               32'h00000000, 32'hFFFFFFFF, 1'b0};
    tv[4]  = '{3'b011, 32'h00000001, 32'h00000001,
               32'h00000001, 32'h00000000, 1'b0};
    tv[5]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tv[6]  = '{3'b101, 32'h00000007, 32'h00000000,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1};
    tv[7]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF,
               32'h00000000, 32'h80000000, 1'b0};
    tv[8]  = '{3'b101, 32'h00000064, 32'h00000007,
               32'h00000002, 32'h0000000E, 1'b0};
    tv[9]  = '{3'b100, 32'h00000007, 32'hFFFFFFFE,
               32'h00000001, 32'hFFFFFFFD, 1'b0};
    tv[10] = '{3'b010, 32'hFFFFFFFF, 32'h00000002,
               32'h00000001, 32'hFFFFFFFB, 1'b0};
    tv[11] = '{3'b000, 32'h80000000, 32'h80000000,
               32'h40000000, 32'h00000000, 1'b0};
    tv[12] = '{3'b001, 32'h12345678, 32'h00000000,
               32'h00000000, 32'h00000000, 1'b0};
    tv[13] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1'b0};
    tv[14] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFC, 32'h00000002, 1'b0};
    tv[15] = '{3'b100, 32'hFFFFFFF9, 32'h00000000,
               32'hFFFFFFFC, 32'h00000002, 1'b1};

    // Reset state, with start asserted to show reset wins
    start = 1'b1; op = 3'b110; a = 32'hA5A5A5A5;
    repeat (2) @(negedge clk);
    start = 1'b0;
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst dz", dz, 0);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 16; i++) begin
      e = '{tv[i].hi, tv[i].lo, tv[i].dz};
      run_op(tv[i].op, tv[i].a, tv[i].b, e,
             $sformatf("vec%0d", i));
    end

    // Random ops against a behavioural model
    mhi = tv[15].hi;
    mlo = tv[15].lo;
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  o;
      logic [31:0] av, bv;
      o  = 3'($urandom_range(0, 5));
      av = $urandom;
      bv = $urandom;
      if (i % 3 == 1) bv = bv % 32'd17;
      if (o[2]) begin
        if (bv == 0) bv = 32'd5;
        if (!o[0] && bv == 32'hFFFFFFFF) bv = 32'd3;
        if (o[0]) begin
          mlo = av / bv;
          mhi = av % bv;
        end else begin
          int sa, sbv;
          sa  = av;
          sbv = bv;
          mlo = 32'(sa / sbv);
          mhi = 32'(sa % sbv);
        end
      end else begin
        if (o[0])
          pr = {32'b0, av} * {32'b0, bv};
        else
          pr = {{32{av[31]}}, av} * {{32{bv[31]}}, bv};
        if (o[1]) {mhi, mlo} = {mhi, mlo} + pr;
        else      {mhi, mlo} = pr;
      end
      e = '{mhi, mlo, 1'b0};
      run_op(o, av, bv, e, $sformatf("rand%0d", i));
    end

    // Start/op/operand changes while busy are ignored
    start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd5;
    sb_q.push_back('{32'd0, 32'd15, 1'b0});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin @(negedge clk); cyc++; end
    start = 1'b1; op = 3'b001; a = 32'd100; b = 32'd100;
    @(negedge clk); cyc++;
    op = 3'b110; a = 32'hDEADBEEF;
    @(negedge clk); cyc++;
    start = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk); cyc++;
    end
    chk("ign done", done, 1);
    chk("ign latency", cyc, 34);
    pop_cmp("ign");
    @(negedge clk);

    // Reset mid-operation aborts without done
    start = 1'b1; op = 3'b001; a = 32'd9; b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    begin
      bit seen = 0;
      for (int k = 0; k < 40; k++) begin
        if (done) seen = 1;
        @(negedge clk);
      end
      chk("abort no done", seen, 0);
    end

    // WIDTH=8 instance
    start8 = 1'b1; op8 = 3'b001; a8 = 8'd200; b8 = 8'd200;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 30) begin
      @(negedge clk); cyc++;
    end
    chk("w8 done", done8, 1);
    chk("w8 latency", cyc, 10);
    chk("w8 hi", hi8, 8'h9C);
    chk("w8 lo", lo8, 8'h40);
    chk("w8 dz", dz8, 0);
    @(negedge clk);
    chk("w8 idle", busy8, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
